// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a
// valid/ready handshake and applies the sequential/branch/jump next-PC choice.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;

  assign pc_plus4_s = pc_q + 32'd4;

  // Next-PC select; jump outranks a taken branch, and branch targets are word-aligned.
  always_comb begin
    next_pc_s = pc_plus4_s;
    if (jump) begin
      next_pc_s = {pc_plus4_s[31:28], instr_q[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc_s = {branch_target[31:2], 2'b00};
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // State transitions and register updates for the single in-flight fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end else begin
          state_d = FETCH;
        end
      end
      VALID: begin
        if (!stall) begin
          pc_d          = next_pc_s;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = FETCH;
        end else begin
          state_d = VALID;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Handshake and qualifier outputs come straight from registered state.
  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == VALID);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_s;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a second instance with RESET_PC near the top
// of memory exercises PC wrap-around.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pc_plus4, fetch_count;
  logic [5:0]  op;

  logic        w_imem_req, w_instr_valid;
  logic [31:0] w_imem_addr, w_instr, w_pc, w_pc_plus4, w_fetch_count;
  logic [5:0]  w_op;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] ADD_INSTR = 32'h0109_5020;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .instr(instr), .op(op), .instr_valid(instr_valid), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .reset_n(reset_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .instr(w_instr), .op(w_op), .instr_valid(w_instr_valid), .pc(w_pc),
    .pc_plus4(w_pc_plus4), .fetch_count(w_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0; jump = 1'b0;
    #2;
    total++;
    if ({imem_req, instr_valid, pc, instr, fetch_count} !== {1'b0, 1'b0, 32'd0, 32'd0, 32'd0})
      $display("FAIL reset_state: req=%0b valid=%0b pc=%h instr=%h cnt=%0d, want 0/0/0/0/0",
               imem_req, instr_valid, pc, instr, fetch_count);
    else passed++;
    tick(); tick();
    reset_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0) $display("FAIL boot_no_req: req=%0b want 0", imem_req);
    else passed++;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0)
      $display("FAIL first_req: req=%0b addr=%h want 1/00000000", imem_req, imem_addr);
    else passed++;
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1; imem_rdata = ADD_INSTR; stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'(4 * i))
        $display("FAIL seq_fetch%0d: req=%0b valid=%0b addr=%h want 1/0/%h",
                 i, imem_req, instr_valid, imem_addr, 32'(4 * i));
      else passed++;
      tick();
      total++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== ADD_INSTR || op !== 6'd0)
        $display("FAIL seq_valid%0d: valid=%0b req=%0b instr=%h op=%h want 1/0/%h/00",
                 i, instr_valid, imem_req, instr, op, ADD_INSTR);
      else passed++;
      tick();
    end
    total++;
    if (fetch_count !== 32'd4 || imem_addr !== 32'h10)
      $display("FAIL seq_count: cnt=%0d addr=%h want 4/00000010", fetch_count, imem_addr);
    else passed++;
  endtask

  task automatic test_ready_wait();
    imem_ready = 1'b0; imem_rdata = 32'h8C22_0004;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0)
        $display("FAIL wait%0d: req=%0b addr=%h valid=%0b want 1/00000010/0",
                 i, imem_req, imem_addr, instr_valid);
      else passed++;
    end
    imem_ready = 1'b1;
    tick();
    total++;
    if (instr_valid !== 1'b1 || instr !== 32'h8C22_0004 || op !== 6'h23 || pc !== 32'h10)
      $display("FAIL wait_capture: valid=%0b instr=%h op=%h pc=%h want 1/8c220004/23/00000010",
               instr_valid, instr, op, pc);
    else passed++;
    tick();
  endtask

  task automatic test_stall();
    imem_ready = 1'b1; imem_rdata = ADD_INSTR; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); tick();
    end
    stall = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      branch_taken  = (i == 2);
      branch_target = 32'h0000_0400;
      tick();
      total++;
      if (pc !== 32'h20 || instr_valid !== 1'b1 || instr !== ADD_INSTR ||
          fetch_count !== 32'd8 || imem_req !== 1'b0)
        $display("FAIL stall%0d: pc=%h valid=%0b instr=%h cnt=%0d req=%0b want 00000020/1/%h/8/0",
                 i, pc, instr_valid, instr, fetch_count, imem_req, ADD_INSTR);
      else passed++;
    end
    branch_taken = 1'b0;
    stall = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h24 || fetch_count !== 32'd9)
      $display("FAIL stall_release: req=%0b addr=%h cnt=%0d want 1/00000024/9",
               imem_req, imem_addr, fetch_count);
    else passed++;
  endtask

  task automatic test_jump();
    tick();
    branch_taken = 1'b1; branch_target = 32'h0000_1000;
    tick();
    branch_taken = 1'b0;
    total++;
    if (imem_addr !== 32'h1000)
      $display("FAIL branch_to_1000: addr=%h want 00001000", imem_addr);
    else passed++;
    imem_rdata = 32'h0800_0040;
    tick();
    total++;
    if (op !== 6'd2 || pc !== 32'h1000)
      $display("FAIL jump_held: op=%h pc=%h want 02/00001000", op, pc);
    else passed++;
    jump = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_2000;
    tick();
    jump = 1'b0; branch_taken = 1'b0;
    total++;
    if (imem_addr !== 32'h0000_0100)
      $display("FAIL jump_priority: addr=%h want 00000100", imem_addr);
    else passed++;
  endtask

  task automatic test_branch();
    imem_rdata = ADD_INSTR;
    tick();
    total++;
    if (pc !== 32'h100 || pc_plus4 !== 32'h104)
      $display("FAIL pc_plus4: pc=%h pc_plus4=%h want 00000100/00000104", pc, pc_plus4);
    else passed++;
    branch_taken = 1'b1; branch_target = 32'h0000_0083;
    tick();
    branch_taken = 1'b0;
    total++;
    if (imem_addr !== 32'h80)
      $display("FAIL branch_align: addr=%h want 00000080", imem_addr);
    else passed++;
  endtask

  task automatic test_reset_midfetch();
    imem_ready = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80)
      $display("FAIL pre_reset_wait: req=%0b addr=%h want 1/00000080", imem_req, imem_addr);
    else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || pc !== 32'd0 || fetch_count !== 32'd0 || instr_valid !== 1'b0)
      $display("FAIL async_reset: req=%0b pc=%h cnt=%0d valid=%0b want 0/0/0/0",
               imem_req, pc, fetch_count, instr_valid);
    else passed++;
    imem_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL late_ready_boot: req=%0b valid=%0b want 0/0", imem_req, instr_valid);
    else passed++;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr_valid !== 1'b0 || fetch_count !== 32'd0)
      $display("FAIL refetch: req=%0b addr=%h valid=%0b cnt=%0d want 1/0/0/0",
               imem_req, imem_addr, instr_valid, fetch_count);
    else passed++;
  endtask

  task automatic test_wrap();
    total++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'd0)
      $display("FAIL wrap_first: req=%0b addr=%h pc_plus4=%h want 1/fffffffc/00000000",
               w_imem_req, w_imem_addr, w_pc_plus4);
    else passed++;
    imem_ready = 1'b1; stall = 1'b0;
    tick(); tick();
    total++;
    if (w_imem_addr !== 32'd0 || w_fetch_count !== 32'd1 || imem_addr !== 32'd4)
      $display("FAIL wrap_second: waddr=%h wcnt=%0d addr=%h want 00000000/1/00000004",
               w_imem_addr, w_fetch_count, imem_addr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ready_wait();
    test_stall();
    test_jump();
    test_branch();
    test_reset_midfetch();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
